mux_arbiter: RTL and testbench

Round-robin arbiter that shares the 4:1 `mux` datapath among four requesters. It drives the mux select lines and a one-hot grant vector, and routes the winning requester's data bit to a single output. It bounds how long one owner may hold the mux and pulses a flag when it forcibly preempts an owner. It sits directly above the encoder/decoder/mux group in the ALU datapath.

---
 rtl/mux_arbiter_pkg.sv | 19 +
 rtl/mux_arbiter_rr_pick.sv | 25 ++
 rtl/mux_arbiter.sv | 103 ++++++++++
 tb/tb_mux_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
// Shared constants and types for the round-robin mux arbiter.
// Imported by the arbiter top and its pick sub-module.
package mux_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] s);
        onehot    = '0;
        onehot[s] = 1'b1;
    endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req after ptr, wrapping,
// with ptr itself scanned last.
module rr_pick
    import mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan from lowest priority up so the highest priority hit wins.
    always_comb begin
        valid = |req;
        idx   = ptr;
        cand  = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) idx = cand;
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin owner of the 4:1 mux with bounded hold and a mandatory
// one-cycle gap between owners.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] data_in,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] select_lines,
    output logic             busy,
    output logic             data_out,
    output logic             timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             to_q, to_d;

    logic [SEL_W-1:0] pick_ptr;
    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;
    logic             others;

    // In GAP the pick already sees the just-released owner as pointer.
    assign pick_ptr = (state_q == ST_GAP) ? sel_q : ptr_q;

    rr_pick u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        others  = |(req & ~onehot(sel_q));
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (!req[sel_q]) begin
                    state_d = ST_GAP;
                end else if (cnt_q == HOLD_LAST && others) begin
                    state_d = ST_GAP;
                    to_d    = 1'b1;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_GAP: begin
                ptr_d = sel_q;
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd3;
            sel_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign busy         = (state_q == ST_GRANT);
    assign select_lines = sel_q;
    assign grant        = busy ? onehot(sel_q) : '0;
    assign timeout      = to_q;
    assign data_out     = busy & data_in[sel_q];

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed table, hand sequences,
// and random traffic against a cycle-level reference model.
module tb_mux_arbiter;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] data_in;
    logic [3:0] grant;
    logic [1:0] select_lines;
    logic       busy;
    logic       data_out;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    mux_arbiter #(.MAX_HOLD(MH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .data_in      (data_in),
        .grant        (grant),
        .select_lines (select_lines),
        .busy         (busy),
        .data_out     (data_out),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index, cycles held so far, gap/busy flags.
    int m_ptr, m_sel, m_held;
    bit m_busy, m_gap, m_to;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic m_reset();
        m_ptr = 3; m_sel = 0; m_held = 0;
        m_busy = 0; m_gap = 0; m_to = 0;
    endtask

    task automatic m_step(input logic [3:0] r);
        int w;
        logic [3:0] oth;
        m_to = 0;
        if (m_gap) begin
            m_gap = 0;
            m_ptr = m_sel;
            w = pick(r, m_ptr);
            if (w >= 0) begin m_busy = 1; m_sel = w; m_held = 1; end
        end else if (m_busy) begin
            oth = r;
            oth[m_sel] = 1'b0;
            if (!r[m_sel]) begin
                m_busy = 0; m_gap = 1;
            end else if (m_held >= MH && oth != 0) begin
                m_busy = 0; m_gap = 1; m_to = 1;
            end else begin
                m_held++;
            end
        end else begin
            w = pick(r, m_ptr);
            if (w >= 0) begin m_busy = 1; m_sel = w; m_held = 1; end
        end
    endtask

    task automatic m_check(input string tag);
        logic [3:0] g;
        logic [1:0] s;
        g = m_busy ? (4'b1 << m_sel) : 4'b0;
        s = 2'(m_sel);
        chk({tag, ".grant"}, grant, g);
        chk({tag, ".sel"}, {2'b0, select_lines}, {2'b0, s});
        chk({tag, ".busy"}, {3'b0, busy}, {3'b0, m_busy});
        chk({tag, ".timeout"}, {3'b0, timeout}, {3'b0, m_to});
        chk({tag, ".dout"}, {3'b0, data_out},
            {3'b0, m_busy & data_in[m_sel]});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        data_in = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    typedef struct {
        logic [3:0] r;
        logic [3:0] d;
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       t;
        logic       o;
    } vec_t;

    vec_t tbl[12];
    logic [3:0] r;
    int c, own, pos;

    initial begin
        // Single requester, then release coincident with a new request.
        tbl[0]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 0, 1};
        tbl[1]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0, 0};
        tbl[2]  = '{4'b0100, 4'b1011, 4'b0100, 2'd2, 1, 0, 0};
        tbl[3]  = '{4'b0000, 4'b1111, 4'b0000, 2'd2, 0, 0, 0};
        tbl[4]  = '{4'b0000, 4'b1111, 4'b0000, 2'd2, 0, 0, 0};
        tbl[5]  = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1, 0, 1};
        tbl[6]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0, 0};
        tbl[7]  = '{4'b0100, 4'b1111, 4'b0000, 2'd0, 0, 0, 0};
        tbl[8]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 0, 1};
        tbl[9]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0, 0};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 0, 0};
        tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 0, 0};

        do_reset();
        chk("rst.grant", grant, 4'b0);
        chk("rst.sel", {2'b0, select_lines}, 4'b0);
        chk("rst.busy", {3'b0, busy}, 4'b0);
        chk("rst.timeout", {3'b0, timeout}, 4'b0);
        chk("rst.dout", {3'b0, data_out}, 4'b0);

        for (int i = 0; i < 12; i++) begin
            req = tbl[i].r;
            data_in = tbl[i].d;
            @(negedge clk);
            chk($sformatf("tbl%0d.grant", i), grant, tbl[i].g);
            chk($sformatf("tbl%0d.sel", i), {2'b0, select_lines}, {2'b0, tbl[i].s});
            chk($sformatf("tbl%0d.busy", i), {3'b0, busy}, {3'b0, tbl[i].b});
            chk($sformatf("tbl%0d.to", i), {3'b0, timeout}, {3'b0, tbl[i].t});
            chk($sformatf("tbl%0d.dout", i), {3'b0, data_out}, {3'b0, tbl[i].o});
        end

        // Lone long requester keeps the grant with no timeout.
        req = 4'b0010;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("lone.grant", grant, 4'b0010);
            chk("lone.to", {3'b0, timeout}, 4'b0);
        end

        // Full contention from reset: 4 cycles each, 1 gap with timeout.
        do_reset();
        req = 4'b1111;
        for (c = 1; c <= 25; c++) begin
            @(negedge clk);
            pos = (c - 1) % 5;
            own = ((c - 1) / 5) % 4;
            if (pos < 4) begin
                chk($sformatf("rr%0d.grant", c), grant, 4'b1 << own);
                chk($sformatf("rr%0d.to", c), {3'b0, timeout}, 4'b0);
            end else begin
                chk($sformatf("rr%0d.grant", c), grant, 4'b0);
                chk($sformatf("rr%0d.to", c), {3'b0, timeout}, 4'b1);
            end
        end

        // Data routing with owner 3, same-cycle response to data_in.
        do_reset();
        req = 4'b1000;
        data_in = 4'b1000;
        @(negedge clk);
        chk("route.sel", {2'b0, select_lines}, 4'd3);
        chk("route.d1", {3'b0, data_out}, 4'b1);
        data_in = 4'b0111;
        #1;
        chk("route.d0", {3'b0, data_out}, 4'b0);
        data_in = 4'b1111;
        req = 4'b0000;
        @(negedge clk);
        chk("route.gap", {3'b0, data_out}, 4'b0);

        // Asynchronous reset mid-grant, between edges.
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        chk("ar.pre", grant, 4'b0100);
        #2;
        reset = 1'b1;
        #1;
        chk("ar.grant", grant, 4'b0);
        chk("ar.busy", {3'b0, busy}, 4'b0);
        chk("ar.sel", {2'b0, select_lines}, 4'b0);
        @(negedge clk);
        reset = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        chk("ar.first", grant, 4'b0001);

        // Random traffic against the model.
        do_reset();
        r = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 3)] ^= 1'b1;
            req = r;
            data_in = 4'($urandom_range(0, 15));
            @(posedge clk);
            m_step(r);
            @(negedge clk);
            m_check($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
